rx_chan_pack: RTL and testbench
===============================

// Module: rx_chan_pack
// PURPOSE
//  Multi-channel RX output packer/buffer behind N parallel RX chains (mixer+CIC) on adc_clk.
//  Captures each channel's decimated I/Q sample on its avail strobe and serialises it into 16-bit words.
//  Channels are served round-robin; each sample is tagged and formatted by runtime mode into a word FIFO drained by the CPU read path.
//  Generalises the single-channel rd_i/rd_q/packed-8+8 output: N channels, 16/24/8+8 formats, buffering, overflow reporting.
// PARAMETERS
//  NCHAN  4     number of RX channels, 1..16
//  WIDTH  24    I/Q sample width (RXO_BITS), 16..32
//  DEPTH  1024  FIFO depth in 16-bit words, power of 2, >=8
//  AW     clog2(DEPTH)  derived, not overridden
// PORTS
//  adc_clk   in   1             sole clock
//  reset     in   1             asynchronous, active-high
//  mode      in   2             0=16b, 1=24b, 2=8+8 packed, 3=treated as 0
//  chan_en   in   NCHAN         per-channel capture enable
//  in_avail  in   NCHAN         1-cycle sample strobes, one per channel
//  in_i      in   NCHAN*WIDTH   flattened I samples, ch k at [k*WIDTH +: WIDTH], signed
//  in_q      in   NCHAN*WIDTH   flattened Q samples, same layout
//  rd        in   1             pop strobe, one word per cycle
//  dout      out  16            FIFO head word, valid while !empty
//  empty     out  1             FIFO empty
//  count     out  AW+1          words held, 0..DEPTH
//  ovfl      out  1             sticky overflow/drop flag
//  ovfl_clr  in   1             clear ovfl (set wins if same cycle)
// BEHAVIOUR
//  Reset: pointers/count=0, empty=1, dout=0, ovfl=0, all pending=0, FSM=IDLE. Async assert, sync release.
//  Capture: in_avail[k]&chan_en[k] -> hold_i/q[k]<=sample, pending[k]<=1 next edge. chan_en=0 ignores strobe.
//  Overrun: capture while pending[k]=1 and ch k not being granted -> overwrite, ovfl<=1.
//  Same-cycle grant of k and new capture on k: grant uses old held value; new value latched, pending[k] stays 1.
//  FSM IDLE: pick first pending ch from rr_ptr upward (wrap NCHAN-1->0); latch mode (3->0), ch, I, Q;
//   clear pending; rr_ptr<=ch+1 (wrap). Then -> EMIT. No pending -> stay IDLE.
//  Words/sample W: mode0=3, mode1=4, mode2=2 (header included).
//  Space check at grant: DEPTH-count < W -> drop sample, ovfl<=1, pending cleared, stay IDLE. No partial samples ever.
//  EMIT: one word written per cycle, in order:
//   hdr   {8'hA5, mode[1:0], 2'b00, ch[3:0]}
//   mode0 I[15:0], Q[15:0]
//   mode1 I[W-1-:16], Q[W-1-:16], {I[W-17-:8], Q[W-17-:8]}
//   mode2 {I[W-1-:8], Q[W-1-:8]}
//  After last word -> IDLE; next grant earliest following cycle. Mode changes mid-sample have no effect.
//  Latency: strobe at edge n -> pending n+1 -> header written n+2 if idle -> head visible n+3.
//  FIFO: first-word-fall-through; dout updates the cycle after write into empty FIFO or after rd.
//  rd while empty ignored (no underflow, count stays 0). Simultaneous write+rd: count unchanged.
//  Pointers wrap modulo DEPTH; count==DEPTH reachable; writes never exceed it (space check).
//  Arithmetic: fields are bit slices only, no rounding/saturation; sign carried in MSBs.
// TESTING
//  T1 NCHAN=4, mode0, ch2 I=24'h123456 Q=24'hFEDCBA -> words A502,3456,DCBA; count=3.
//  T2 mode1 same sample ch2 -> A542,1234,FEDC,56BA; mode2 -> A582,12FE.
//  T3 all 4 ch strobe same cycle, rr_ptr=0 -> headers A500,A501,A502,A503 in order; next sample from ch0.
//  T4 DEPTH=8, no rd, mode0: 2 samples -> count=6; 3rd dropped, ovfl=1, count=6.
//  T5 ch1 strobed twice before grant -> second sample emitted, ovfl=1; ovfl_clr -> 0.
//  T6 reset during EMIT after 1 word -> count=0, empty=1, pending=0, FSM IDLE; rd while empty no change.

Source files
------------

// File: rtl/rx_chan_pack.sv
// rx_chan_pack: multi-channel RX output packer.
// Captures per-channel decimated I/Q samples on their avail strobes, serves the
// pending channels round-robin and formats each sample into a tagged group of
// 16-bit words pushed into a first-word-fall-through FIFO read by the CPU.
//
// Ports
//   adc_clk   clock
//   reset     asynchronous active-high reset
//   mode      output format: 0=16b, 1=24b, 2=8+8 packed, 3=same as 0
//   chan_en   per-channel capture enable
//   in_avail  per-channel one-cycle sample strobes
//   in_i/in_q flattened signed samples, channel k at [k*WIDTH +: WIDTH]
//   rd        pop one word from the FIFO
//   dout      FIFO head word, valid while !empty
//   empty     FIFO empty
//   count     words held, 0..DEPTH
//   ovfl      sticky overrun/drop flag
//   ovfl_clr  clear ovfl (a same-cycle set wins)
module rx_chan_pack #(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                     adc_clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic [NCHAN-1:0]         chan_en,
  input  logic [NCHAN-1:0]         in_avail,
  input  logic [NCHAN*WIDTH-1:0]   in_i,
  input  logic [NCHAN*WIDTH-1:0]   in_q,
  input  logic                     rd,
  output logic [15:0]              dout,
  output logic                     empty,
  output logic [AW:0]              count,
  output logic                     ovfl,
  input  logic                     ovfl_clr
);

  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [0:0] {S_IDLE, S_EMIT} state_e;

  // Per-channel holding registers
  logic [WIDTH-1:0] hold_i_q [NCHAN];
  logic [WIDTH-1:0] hold_q_q [NCHAN];
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [NCHAN-1:0] cap_c, gnt_oh_c;
  logic             ovr_c;

  // Emission state
  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       ch_q, ch_d;
  logic [WIDTH-1:0] smp_i_q, smp_i_d;
  logic [WIDTH-1:0] smp_q_q, smp_q_d;
  logic [1:0]       widx_q, widx_d;
  logic [CW-1:0]    rr_q, rr_d;

  logic             gnt_vld_c, gnt_fire_c, drop_c, wr_en_c;
  logic [CW-1:0]    gnt_ch_c;
  logic [1:0]       mode_eff_c, last_c;
  logic [2:0]       nw_c;
  logic [AW:0]      free_c;
  logic [15:0]      word_c;
  logic [WIDTH+7:0] si_pad_c, sq_pad_c;

  // FIFO
  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [15:0]      dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             ovfl_q, ovfl_d;
  logic             pop_c;

  assign dout  = dout_q;
  assign empty = empty_q;
  assign count = count_q;
  assign ovfl  = ovfl_q;

  // Round-robin arbiter: first pending channel at or after rr_q, wrapping
  always_comb begin
    int unsigned idx;
    gnt_vld_c = 1'b0;
    gnt_ch_c  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NCHAN) idx = idx - NCHAN;
      if (!gnt_vld_c && pend_q[CW'(idx)]) begin
        gnt_vld_c = 1'b1;
        gnt_ch_c  = CW'(idx);
      end
    end
  end

  // Pending flags; a grant consumes the old held value, a same-cycle capture re-arms
  always_comb begin
    cap_c    = in_avail & chan_en;
    gnt_oh_c = '0;
    if (gnt_fire_c) gnt_oh_c[gnt_ch_c] = 1'b1;
    pend_d   = (pend_q & ~gnt_oh_c) | cap_c;
    ovr_c    = |(cap_c & pend_q & ~gnt_oh_c);
  end

  // Words per sample for the incoming mode, and last word index for the latched one
  always_comb begin
    mode_eff_c = (mode == 2'd3) ? 2'd0 : mode;
    case (mode_eff_c)
      2'd0:    nw_c = 3'd3;
      2'd1:    nw_c = 3'd4;
      default: nw_c = 3'd2;
    endcase
    case (mode_q)
      2'd0:    last_c = 2'd2;
      2'd1:    last_c = 2'd3;
      default: last_c = 2'd1;
    endcase
    free_c = (AW+1)'(DEPTH) - count_q;
  end

  // Grant / emit FSM
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    smp_i_d    = smp_i_q;
    smp_q_d    = smp_q_q;
    widx_d     = widx_q;
    rr_d       = rr_q;
    gnt_fire_c = 1'b0;
    drop_c     = 1'b0;
    wr_en_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld_c) begin
          gnt_fire_c = 1'b1;
          rr_d = (32'(gnt_ch_c) == NCHAN - 1) ? '0 : gnt_ch_c + CW'(1);
          // Whole sample must fit, otherwise it is discarded
          if (free_c < (AW+1)'(nw_c)) begin
            drop_c = 1'b1;
          end else begin
            mode_d  = mode_eff_c;
            ch_d    = 4'(gnt_ch_c);
            smp_i_d = hold_i_q[gnt_ch_c];
            smp_q_d = hold_q_q[gnt_ch_c];
            widx_d  = 2'd0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        wr_en_c = 1'b1;
        widx_d  = widx_q + 2'd1;
        if (widx_q == last_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output word formatter; low-byte padding keeps the 24b extension slice legal at WIDTH=16
  always_comb begin
    si_pad_c = {smp_i_q, 8'h00};
    sq_pad_c = {smp_q_q, 8'h00};
    word_c   = {8'hA5, mode_q, 2'b00, ch_q};
    if (widx_q != 2'd0) begin
      case (mode_q)
        2'd0: word_c = (widx_q == 2'd1) ? smp_i_q[15:0] : smp_q_q[15:0];
        2'd1: begin
          case (widx_q)
            2'd1:    word_c = smp_i_q[WIDTH-1 -: 16];
            2'd2:    word_c = smp_q_q[WIDTH-1 -: 16];
            default: word_c = {si_pad_c[WIDTH-9 -: 8], sq_pad_c[WIDTH-9 -: 8]};
          endcase
        end
        default: word_c = {smp_i_q[WIDTH-1 -: 8], smp_q_q[WIDTH-1 -: 8]};
      endcase
    end
  end

  // FIFO next state; dout only reloads from words already stored before this edge
  always_comb begin
    pop_c    = rd & ~empty_q;
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    count_d  = count_q + (AW+1)'(wr_en_c) - (AW+1)'(pop_c);
    empty_d  = ((count_q - (AW+1)'(pop_c)) == '0);
    dout_d   = empty_d ? dout_q : mem_q[rd_ptr_d];
    ovfl_d   = ovfl_q;
    if (ovfl_clr)        ovfl_d = 1'b0;
    if (drop_c || ovr_c) ovfl_d = 1'b1;
  end

  // Control and datapath registers
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      ch_q     <= 4'd0;
      smp_i_q  <= '0;
      smp_q_q  <= '0;
      widx_q   <= 2'd0;
      rr_q     <= '0;
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= 16'h0000;
      empty_q  <= 1'b1;
      ovfl_q   <= 1'b0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
        hold_i_q[k] <= '0;
        hold_q_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ch_q     <= ch_d;
      smp_i_q  <= smp_i_d;
      smp_q_q  <= smp_q_d;
      widx_q   <= widx_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_q + AW'(wr_en_c);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      ovfl_q   <= ovfl_d;
      for (int unsigned k = 0; k < NCHAN; k++) begin
        if (cap_c[k]) begin
          hold_i_q[k] <= in_i[k*WIDTH +: WIDTH];
          hold_q_q[k] <= in_q[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Word storage, no reset needed
  always_ff @(posedge adc_clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= word_c;
  end

endmodule

// File: tb/tb_rx_chan_pack.sv
// tb_rx_chan_pack: directed bench for rx_chan_pack (NCHAN=4, WIDTH=24, DEPTH=8).
module tb_rx_chan_pack;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 24;
  localparam int unsigned D   = 8;
  localparam int unsigned AW  = 3;

  logic              adc_clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic [NCH-1:0]    chan_en = '1;
  logic [NCH-1:0]    in_avail = '0;
  logic [NCH*W-1:0]  in_i = '0;
  logic [NCH*W-1:0]  in_q = '0;
  logic              rd = 1'b0;
  logic [15:0]       dout;
  logic              empty;
  logic [AW:0]       count;
  logic              ovfl;
  logic              ovfl_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  rx_chan_pack #(.NCHAN(NCH), .WIDTH(W), .DEPTH(D)) dut (
    .adc_clk (adc_clk),
    .reset   (rst),
    .mode    (mode),
    .chan_en (chan_en),
    .in_avail(in_avail),
    .in_i    (in_i),
    .in_q    (in_q),
    .rd      (rd),
    .dout    (dout),
    .empty   (empty),
    .count   (count),
    .ovfl    (ovfl),
    .ovfl_clr(ovfl_clr)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge adc_clk);
  endtask

  task automatic set_smp(input int ch, input logic [23:0] i, input logic [23:0] q);
    in_i[ch*W +: W] = i;
    in_q[ch*W +: W] = q;
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    in_avail = m;
    tick();
    in_avail = '0;
  endtask

  // Wait (bounded) for a word, check it, then pop it
  task automatic pop_expect(input string tag, input logic [15:0] exp);
    int n = 0;
    while (empty && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(empty), 32'd0);
    check(tag, 32'(dout), 32'(exp));
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int target);
    int n = 0;
    while (32'(count) != target && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(count), 32'(target));
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    wait_n(2);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    check("rst_ovfl",  32'(ovfl),  32'd0);
    rst = 1'b0;
    tick();

    // T1: mode0, ch2, with latency checks
    mode = 2'd0;
    set_smp(2, 24'h123456, 24'hFEDCBA);
    pulse(4'b0100);
    wait_n(2);
    check("t1_cnt_hdr",   32'(count), 32'd1);
    check("t1_empty_hdr", 32'(empty), 32'd1);
    tick();
    check("t1_vis_empty", 32'(empty), 32'd0);
    check("t1_vis_dout",  32'(dout),  32'hA502);
    tick();
    check("t1_count3", 32'(count), 32'd3);
    pop_expect("t1_w0", 16'hA502);
    pop_expect("t1_w1", 16'h3456);
    pop_expect("t1_w2", 16'hDCBA);
    check("t1_empty_end", 32'(empty), 32'd1);
    check("t1_count_end", 32'(count), 32'd0);

    // T2: mode1 (mode changed right after grant must not matter), mode2, mode3
    mode = 2'd1;
    pulse(4'b0100);
    tick();
    mode = 2'd2;
    pop_expect("t2m1_w0", 16'hA542);
    pop_expect("t2m1_w1", 16'h1234);
    pop_expect("t2m1_w2", 16'hFEDC);
    pop_expect("t2m1_w3", 16'h56BA);
    pulse(4'b0100);
    pop_expect("t2m2_w0", 16'hA582);
    pop_expect("t2m2_w1", 16'h12FE);
    mode = 2'd3;
    pulse(4'b0100);
    pop_expect("t2m3_w0", 16'hA502);
    pop_expect("t2m3_w1", 16'h3456);
    pop_expect("t2m3_w2", 16'hDCBA);

    // T3: all four channels at once, rr from 0, fills FIFO exactly
    do_reset();
    mode = 2'd2;
    for (int k = 0; k < 4; k++) set_smp(k, {8'(8'h10 + k), 16'h0}, {8'(8'h20 + k), 16'h0});
    pulse(4'b1111);
    wait_count("t3_full", 8);
    wait_n(3);
    check("t3_ovfl", 32'(ovfl), 32'd0);
    pop_expect("t3_h0", 16'hA580);
    pop_expect("t3_d0", 16'h1020);
    pop_expect("t3_h1", 16'hA581);
    pop_expect("t3_d1", 16'h1121);
    pop_expect("t3_h2", 16'hA582);
    pop_expect("t3_d2", 16'h1222);
    pop_expect("t3_h3", 16'hA583);
    pop_expect("t3_d3", 16'h1323);
    pulse(4'b1001);
    pop_expect("t3_wrap_h0", 16'hA580);
    pop_expect("t3_wrap_d0", 16'h1020);
    pop_expect("t3_wrap_h3", 16'hA583);
    pop_expect("t3_wrap_d3", 16'h1323);

    // T4: no reads, mode0: two samples fit, third dropped
    mode = 2'd0;
    set_smp(0, 24'h00AAAA, 24'h00BBBB);
    pulse(4'b0001);
    set_smp(1, 24'h00CCCC, 24'h00DDDD);
    pulse(4'b0010);
    wait_count("t4_cnt6", 6);
    check("t4_ovfl_pre", 32'(ovfl), 32'd0);
    set_smp(2, 24'h777777, 24'h888888);
    pulse(4'b0100);
    wait_n(5);
    check("t4_cnt_drop", 32'(count), 32'd6);
    check("t4_ovfl", 32'(ovfl), 32'd1);
    pop_expect("t4_h0", 16'hA500);
    pop_expect("t4_i0", 16'hAAAA);
    pop_expect("t4_q0", 16'hBBBB);
    pop_expect("t4_h1", 16'hA501);
    pop_expect("t4_i1", 16'hCCCC);
    pop_expect("t4_q1", 16'hDDDD);
    wait_n(6);
    check("t4_no_reemit", 32'(count), 32'd0);
    ovfl_clr = 1'b1;
    tick();
    ovfl_clr = 1'b0;
    check("t4_ovfl_clr", 32'(ovfl), 32'd0);

    // T5a: recapture on the grant cycle re-arms the channel without overrun
    set_smp(1, 24'h111111, 24'h222222);
    pulse(4'b0010);
    set_smp(1, 24'h334455, 24'h667788);
    pulse(4'b0010);
    pop_expect("t5a_h0", 16'hA501);
    pop_expect("t5a_i0", 16'h1111);
    pop_expect("t5a_q0", 16'h2222);
    pop_expect("t5a_h1", 16'hA501);
    pop_expect("t5a_i1", 16'h4455);
    pop_expect("t5a_q1", 16'h7788);
    check("t5a_ovfl", 32'(ovfl), 32'd0);

    // T5b: ch1 strobed twice while busy: overwrite, second sample out, ovfl set
    set_smp(0, 24'h0A0B0C, 24'h0D0E0F);
    pulse(4'b0001);
    set_smp(1, 24'h111111, 24'h222222);
    pulse(4'b0010);
    set_smp(1, 24'h334455, 24'h667788);
    pulse(4'b0010);
    pop_expect("t5b_h0", 16'hA500);
    pop_expect("t5b_i0", 16'h0B0C);
    pop_expect("t5b_q0", 16'h0E0F);
    pop_expect("t5b_h1", 16'hA501);
    pop_expect("t5b_i1", 16'h4455);
    pop_expect("t5b_q1", 16'h7788);
    wait_n(6);
    check("t5b_cnt", 32'(count), 32'd0);
    check("t5b_ovfl", 32'(ovfl), 32'd1);
    ovfl_clr = 1'b1;
    tick();
    ovfl_clr = 1'b0;
    check("t5b_ovfl_clr", 32'(ovfl), 32'd0);

    // T6: reset in the middle of an emission
    set_smp(0, 24'h0A0B0C, 24'h0D0E0F);
    pulse(4'b0001);
    wait_n(2);
    check("t6_cnt_pre", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_cnt",   32'(count), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_dout",  32'(dout),  32'd0);
    tick();
    rst = 1'b0;
    wait_n(6);
    check("t6_idle_cnt",   32'(count), 32'd0);
    check("t6_idle_empty", 32'(empty), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t6_rd_empty_cnt", 32'(count), 32'd0);
    check("t6_rd_empty_emp", 32'(empty), 32'd1);
    set_smp(2, 24'h123456, 24'hFEDCBA);
    pulse(4'b0100);
    pop_expect("t6_w0", 16'hA502);
    pop_expect("t6_w1", 16'h3456);
    pop_expect("t6_w2", 16'hDCBA);

    // chan_en low ignores the strobe
    chan_en = 4'b1110;
    pulse(4'b0001);
    wait_n(6);
    check("dis_cnt", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
